// File: rtl/bitstream_tx.sv
// Serial bitstream transmitter: streams a start strobe, idle slots, an LSB-first header and a
// block-fed payload, one bit per clock, towards the PMU serial input.
// The FSM state leads the registered outputs by one cycle; every output register is loaded with
// the value belonging to the cycle after the current state cycle.
module bitstream_tx #(
    parameter int unsigned HEADER_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH  = 128,
    parameter int unsigned PRE_CYCLES   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              opcode,
    input  logic [HEADER_WIDTH-5:0] length,
    input  logic [BLOCK_WIDTH-1:0]  blk_data,
    input  logic                    blk_valid,
    output logic                    blk_ready,
    output logic                    en_o,
    output logic                    data_o,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned PosW = (BLOCK_WIDTH > 1) ? $clog2(BLOCK_WIDTH) : 1;
    localparam logic [HEADER_WIDTH-1:0] CntOne  = HEADER_WIDTH'(1);
    localparam logic [HEADER_WIDTH-1:0] PreLast =
        HEADER_WIDTH'((PRE_CYCLES == 0) ? 0 : PRE_CYCLES - 1);
    localparam logic [HEADER_WIDTH-1:0] HdrLast = HEADER_WIDTH'(HEADER_WIDTH - 1);
    localparam logic [HEADER_WIDTH-1:0] BlkBits = HEADER_WIDTH'(BLOCK_WIDTH);
    localparam logic [PosW-1:0]         PosLast = PosW'(BLOCK_WIDTH - 1);
    localparam logic [PosW-1:0]         PosOne  = PosW'(1);

    typedef enum logic [2:0] {StIdle, StPre, StHdr, StPay, StDone} state_e;

    state_e                  state_q, state_d;
    logic [HEADER_WIDTH-1:0] cnt_q, cnt_d;         // PRE slot, header bit or payload bit index
    logic [PosW-1:0]         pos_q, pos_d;         // bit position inside the current block
    logic [HEADER_WIDTH-1:0] hdr_q, hdr_d;
    logic [HEADER_WIDTH-1:0] len_q, len_d;
    logic [HEADER_WIDTH-1:0] acc_bits_q, acc_bits_d; // accepted blocks times BLOCK_WIDTH
    logic [BLOCK_WIDTH-1:0]  shift_q, shift_d;
    logic [BLOCK_WIDTH-1:0]  hold_q, hold_d;
    logic                    hold_vld_q, hold_vld_d;
    logic                    data_q, data_d;
    logic                    en_q, en_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;

    logic start_acc;
    logic accept;
    logic boundary;
    logic underrun;

    // busy_q also covers the tail cycle whose output still belongs to the transfer
    assign start_acc = (state_q == StIdle) && start && !busy_q;
    assign blk_ready = (state_q != StIdle) && !hold_vld_q && (acc_bits_q < len_q);
    assign accept    = blk_valid && blk_ready;
    assign boundary  = (state_q == StPay) && (pos_q == '0);
    assign underrun  = boundary && !hold_vld_q;

    assign en_o   = en_q;
    assign data_o = data_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pos_q      <= '0;
            hdr_q      <= '0;
            len_q      <= '0;
            acc_bits_q <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            data_q     <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            hdr_q      <= hdr_d;
            len_q      <= len_d;
            acc_bits_q <= acc_bits_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            data_q     <= data_d;
            en_q       <= en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and bit/slot counters
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    cnt_d   = '0;
                    state_d = (PRE_CYCLES == 0) ? StHdr : StPre;
                end
            end
            StPre: begin
                if (cnt_q == PreLast) begin
                    cnt_d   = '0;
                    state_d = StHdr;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StHdr: begin
                if (cnt_q == HdrLast) begin
                    cnt_d   = '0;
                    pos_d   = '0;
                    state_d = (len_q == '0) ? StDone : StPay;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StPay: begin
                if (underrun) begin
                    state_d = StIdle;
                end else if (cnt_q == len_q - CntOne) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntOne;
                    pos_d = (pos_q == PosLast) ? '0 : pos_q + PosOne;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output values for the next cycle plus header/block register updates
    always_comb begin
        hdr_d      = hdr_q;
        len_d      = len_q;
        acc_bits_d = acc_bits_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        data_d     = 1'b0;
        en_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        busy_d     = (state_d != StIdle) || (state_q != StIdle);

        // blk_ready requires an empty holding register, so this never races the boundary move
        if (accept) begin
            hold_d     = blk_data;
            hold_vld_d = 1'b1;
            acc_bits_d = acc_bits_q + BlkBits;
        end

        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    hdr_d      = {length, opcode};
                    len_d      = {4'b0000, length};
                    acc_bits_d = '0;
                    hold_vld_d = 1'b0;
                    en_d       = 1'b1;
                    err_d      = 1'b0;
                end
            end
            StPre: begin
                data_d = 1'b0;
            end
            StHdr: begin
                data_d = hdr_q[0];
                hdr_d  = hdr_q >> 1;
            end
            StPay: begin
                if (boundary) begin
                    if (hold_vld_q) begin
                        data_d     = hold_q[0];
                        shift_d    = hold_q >> 1;
                        hold_vld_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    data_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
                data_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bitstream_tx.sv
// Randomized bench for bitstream_tx: builds the expected serial stream from the header and
// block contents and compares it cycle by cycle, plus control-pulse timing per scenario.
module tb_bitstream_tx;

    localparam int HW  = 32;
    localparam int BW  = 128;
    localparam int PRE = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    opcode;
    logic [HW-5:0] length;
    logic [BW-1:0] blk_data;
    logic          blk_valid;
    logic          blk_ready;
    logic          en_o;
    logic          data_o;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;
    int hs_count = 0;
    bit xfer_over;

    always #5 clk = ~clk;

    bitstream_tx #(
        .HEADER_WIDTH(HW),
        .BLOCK_WIDTH (BW),
        .PRE_CYCLES  (PRE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .length   (length),
        .blk_data (blk_data),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .en_o     (en_o),
        .data_o   (data_o),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Count every completed block handshake
    always @(posedge clk) begin
        if (!rst && blk_valid && blk_ready) hs_count++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // feed < 0: supply every block; abort_at >= 0: reset while payload bit abort_at is shown
    task automatic do_xfer(input string name, input logic [3:0] op, input int len,
                           input int feed_in, input int abort_at, input bit glitch,
                           input bit fixed_blk, input int max_gap);
        logic [BW-1:0] blks[$];
        bit            exp_bits[$];
        logic [HW-1:0] hdr;
        logic [BW-1:0] tmp;
        logic [BW-1:0] key_blk;
        int            nblk;
        int            feed;
        int            k_stop;
        int            mode;
        int            hs_base;
        int            bad;
        int            ctl_bad;
        int            done_seen;

        key_blk = 128'h000102030405060708090A0B0C0D0E0F;
        nblk = (len + BW - 1) / BW;
        feed = (feed_in < 0) ? nblk : feed_in;
        for (int k = 0; k < nblk; k++) blks.push_back(fixed_blk ? key_blk : rand_blk());

        hdr = {len[HW-5:0], op};
        for (int i = 0; i < PRE; i++) exp_bits.push_back(1'b0);
        for (int i = 0; i < HW; i++) exp_bits.push_back(hdr[i]);
        for (int j = 0; j < len; j++) begin
            tmp = blks[j / BW];
            exp_bits.push_back(tmp[j % BW]);
        end

        if (abort_at >= 0) begin
            mode   = 2;
            k_stop = PRE + HW + abort_at + 1;
        end else if (feed < nblk) begin
            mode   = 1;
            k_stop = PRE + HW + feed * BW;
        end else begin
            mode   = 0;
            k_stop = PRE + HW + len;
        end

        hs_base   = hs_count;
        xfer_over = 1'b0;
        start     = 1'b1;
        opcode    = op;
        length    = len[HW-5:0];

        fork
            begin : feeder
                for (int k = 0; k < feed && !xfer_over; k++) begin
                    bit got;
                    int gap;
                    blk_valid = 1'b0;
                    gap = $urandom_range(0, max_gap);
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                    blk_data  = blks[k];
                    blk_valid = 1'b1;
                    got = 1'b0;
                    while (!got && !xfer_over) begin
                        @(negedge clk);
                        if (blk_ready && !xfer_over) begin
                            @(posedge clk);
                            #1;
                            got = 1'b1;
                        end
                    end
                end
                // Keep offering junk so any excess acceptance shows up in the handshake count
                if (feed == nblk && !xfer_over) begin
                    blk_data  = rand_blk();
                    blk_valid = 1'b1;
                end else begin
                    blk_valid = 1'b0;
                end
            end
            begin : monitor
                @(posedge clk);
                #1;
                start = 1'b0;
                check_eq({name, "_en_t0"}, en_o, 1'b1);
                check_eq({name, "_busy_t0"}, busy, 1'b1);
                check_eq({name, "_err_t0"}, err, 1'b0);
                bad     = 0;
                ctl_bad = 0;
                for (int k = 1; k <= k_stop; k++) begin
                    @(posedge clk);
                    #1;
                    if (glitch && k == PRE + 5) begin
                        start  = 1'b1;
                        opcode = ~op;
                        length = 28'(len + 3);
                    end else begin
                        start = 1'b0;
                    end
                    if (data_o !== exp_bits[k-1]) bad++;
                    if (en_o !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || err !== 1'b0)
                        ctl_bad++;
                end
                start = 1'b0;
                check_eq({name, "_stream_bad_bits"}, bad, 0);
                check_eq({name, "_ctl_glitches"}, ctl_bad, 0);
                if (mode == 0) begin
                    @(posedge clk);
                    #1;
                    check_eq({name, "_done_pulse"}, {done, data_o}, 2'b10);
                    @(posedge clk);
                    #1;
                    check_eq({name, "_done_end"}, {done, busy, err}, 3'b000);
                    check_eq({name, "_blocks_acc"}, hs_count - hs_base, nblk);
                end else if (mode == 1) begin
                    @(posedge clk);
                    #1;
                    check_eq({name, "_underrun_err"}, {err, data_o, done}, 3'b100);
                    @(posedge clk);
                    #1;
                    check_eq({name, "_underrun_idle"}, {busy, err, done}, 3'b010);
                    done_seen = 0;
                    repeat (4) begin
                        @(posedge clk);
                        #1;
                        if (done !== 1'b0) done_seen++;
                    end
                    check_eq({name, "_no_done"}, done_seen, 0);
                    check_eq({name, "_blocks_acc"}, hs_count - hs_base, feed);
                end else begin
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    check_eq({name, "_abort_outs"}, {en_o, data_o, blk_ready, busy, done, err},
                             6'b000000);
                end
                xfer_over = 1'b1;
                blk_valid = 1'b0;
            end
        join
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        opcode    = '0;
        length    = '0;
        blk_data  = '0;
        blk_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("reset_outs", {en_o, data_o, blk_ready, busy, done, err}, 6'b000000);
        // start and rst together: reset must win
        start = 1'b1;
        opcode = 4'b0010;
        length = 28'd128;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("start_under_rst", {en_o, busy}, 2'b00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_xfer("keyload", 4'b0010, 128, -1, -1, 1'b0, 1'b1, 0);
        do_xfer("pc2sc", 4'b1010, 200, -1, -1, 1'b0, 1'b0, 20);
        do_xfer("underrun", 4'b1010, 256, 1, -1, 1'b0, 1'b0, 10);
        do_xfer("len0", 4'b0001, 0, -1, -1, 1'b0, 1'b0, 5);
        do_xfer("abort", 4'b1010, 300, -1, 50, 1'b0, 1'b0, 10);
        do_xfer("after_abort", 4'b0001, 150, -1, -1, 1'b0, 1'b0, 10);
        do_xfer("hdr_start", 4'b1010, 170, -1, -1, 1'b1, 1'b0, 15);
        for (int t = 0; t < 8; t++) begin
            logic [3:0] op;
            int         len;
            op  = 4'($urandom());
            len = int'($urandom_range(0, 520));
            do_xfer($sformatf("rand%0d", t), op, len, -1, -1, 1'b0, 1'b0, 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
